booth_mult_sequencer: RTL and testbench

Operand sequencer that sits directly upstream of `booth_multiplier` and owns its start/ack/irq handshake. It accepts signed operand pairs on a valid/ready stream, buffers them in a small FIFO, and issues one job at a time to the multiplier. It returns each 32-bit product on a valid/ready result stream, so software and datapath clients never drive the multiplier's four-phase handshake directly.

---
 rtl/booth_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/booth_mult_sequencer.sv | 132 +++++++++++++
 tb/tb_booth_mult_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier and its operand sequencer.
package booth_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based flags; the not-full flag is registered.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata_c,
  output logic          o_empty_c,
  output logic          o_not_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_not_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_push     = i_push && r_not_full;
  assign w_pop      = i_pop && (r_count != '0);
  assign o_rdata_c  = r_mem[r_rd_ptr];
  assign o_empty_c  = (r_count == '0);
  assign o_not_full = r_not_full;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Queues signed operand pairs and runs booth_multiplier's start/irq/ack handshake one job at a time.
module booth_mult_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 mul_start,
  output logic                 mul_ack,
  output logic                 mul_irq_enable,
  output logic [WIDTH-1:0]     mul_data_a,
  output logic [WIDTH-1:0]     mul_data_b,
  input  logic                 mul_irq,
  input  logic                 mul_busy,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 err_timeout
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t       r_state;
  logic             r_start;
  logic             r_ack;
  logic             r_irq_en;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;
  logic             r_out_valid;
  logic [RES_W-1:0] r_result;
  logic             r_err;
  logic [CNT_W-1:0] r_tmo_cnt;

  logic [RES_W-1:0] w_head;
  logic             w_empty;
  logic             w_not_full;
  logic             w_pop;
  logic             w_unused_busy;

  // Busy is informational only; sequencing relies on irq.
  assign w_unused_busy = mul_busy;

  // A job leaves the FIFO only when idle and the result slot is free.
  assign w_pop = (r_state == IDLE) && !w_empty && !r_out_valid;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (RES_W)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .i_push     (in_valid),
    .i_wdata    ({in_a, in_b}),
    .i_pop      (w_pop),
    .o_rdata_c  (w_head),
    .o_empty_c  (w_empty),
    .o_not_full (w_not_full)
  );

  assign in_ready       = w_not_full;
  assign out_valid      = r_out_valid;
  assign out_result     = r_result;
  assign mul_start      = r_start;
  assign mul_ack        = r_ack;
  assign mul_irq_enable = r_irq_en;
  assign mul_data_a     = r_data_a;
  assign mul_data_b     = r_data_b;
  assign err_timeout    = r_err;

  // Handshake FSM, timeout watchdog and result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_ack       <= 1'b0;
      r_irq_en    <= 1'b1;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_irq_en <= 1'b1;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data_a  <= w_head[RES_W-1:WIDTH];
            r_data_b  <= w_head[WIDTH-1:0];
            r_start   <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= START;
          end
        end
        START: begin
          // irq takes priority over a coincident timeout
          if (mul_irq) begin
            r_result    <= mul_result;
            r_out_valid <= 1'b1;
            r_start     <= 1'b0;
            r_ack       <= 1'b1;
            r_state     <= ACK;
          end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        ACK: begin
          if (!mul_irq) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer with a behavioural multiplier responder.
module tb_booth_mult_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned PW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_result;
  logic          mul_start;
  logic          mul_ack;
  logic          mul_irq_enable;
  logic [W-1:0]  mul_data_a;
  logic [W-1:0]  mul_data_b;
  logic          mul_irq;
  logic          mul_busy;
  logic [PW-1:0] mul_result;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q [$];
  bit never_irq = 1'b0;

  always #5 clk = ~clk;

  booth_mult_sequencer #(.WIDTH(W), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .mul_start(mul_start), .mul_ack(mul_ack), .mul_irq_enable(mul_irq_enable),
    .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
    .mul_irq(mul_irq), .mul_busy(mul_busy), .mul_result(mul_result),
    .err_timeout(err_timeout)
  );

  // Signed product by plain integer arithmetic.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return PW'(sa * sb);
  endfunction

  function automatic logic [W-1:0] rand_op();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  // Multiplier stand-in: four-phase start/irq/ack with random latency; also checks operand stability.
  initial begin : mul_model
    int st;
    int dly;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    st = 0; dly = 0; la = '0; lb = '0;
    mul_irq = 1'b0; mul_busy = 1'b0; mul_result = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        st = 0; mul_irq = 1'b0; mul_busy = 1'b0; mul_result = '0;
      end else begin
        if (st != 0) begin
          checks++;
          if (mul_data_a !== la || mul_data_b !== lb) begin
            failures++;
            $display("FAIL operand_stable got a=%h b=%h want a=%h b=%h", mul_data_a, mul_data_b, la, lb);
          end
        end
        case (st)
          0: if (mul_start) begin
               la = mul_data_a; lb = mul_data_b;
               dly = int'($urandom_range(1, 8)); mul_busy = 1'b1; st = 1;
             end
          1: if (!mul_start) begin
               mul_busy = 1'b0; st = 0;
             end else if (!never_irq) begin
               dly--;
               if (dly == 0) begin
                 mul_irq = 1'b1; mul_busy = 1'b0; mul_result = ref_prod(la, lb); st = 2;
               end
             end
          2: if (mul_ack) begin
               mul_irq = 1'b0; mul_result = $urandom; st = 3;
             end
          default: if (!mul_ack) st = 0;
        endcase
      end
    end
  end

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int t;
    t = 0; ok = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!ok && t < 300) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk); t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output bit ok);
    int t;
    t = 0;
    while (!out_valid && t < 500) begin @(negedge clk); t++; end
    ok = out_valid;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if ({out_valid, mul_start, mul_ack, err_timeout} !== 4'b0000) begin
      failures++; $display("FAIL rst_ctrl got ov/st/ack/err=%b want 0000", {out_valid, mul_start, mul_ack, err_timeout}); end
    checks++; if (out_result !== '0 || mul_data_a !== '0 || mul_data_b !== '0) begin
      failures++; $display("FAIL rst_data got res=%h a=%h b=%h want 0", out_result, mul_data_a, mul_data_b); end
    checks++; if (mul_irq_enable !== 1'b1) begin failures++; $display("FAIL rst_irq_en got %b want 1", mul_irq_enable); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL post_rst_idle got start=%b want 0", mul_start); end
  endtask

  task automatic test_basic_products();
    logic [W-1:0]  va [3];
    logic [W-1:0]  vb [3];
    logic [PW-1:0] ve [3];
    bit ok;
    va = '{16'd2, 16'd2, 16'd2};
    vb = '{16'd3, 16'd7, 16'd15};
    ve = '{32'd6, 32'd14, 32'd30};
    out_ready = 1'b0;
    push_job(va[0], vb[0], ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_push0 got accepted=0 want 1"); end
    checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL issue_latency_early got start=%b want 0", mul_start); end
    @(negedge clk);
    checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL issue_latency got start=%b want 1", mul_start); end
    for (int i = 1; i < 3; i++) begin
      push_job(va[i], vb[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_push%0d got accepted=0 want 1", i); end
    end
    for (int i = 0; i < 3; i++) begin
      wait_out_valid(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_wait%0d got out_valid=0 want 1", i); end
      else if (out_result !== ve[i]) begin failures++; $display("FAIL basic_result%0d got %h want %h", i, out_result, ve[i]); end
      take_result();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_clear%0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_signed_extremes();
    logic [W-1:0]  va [5];
    logic [W-1:0]  vb [5];
    logic [PW-1:0] ve [5];
    bit ok;
    va = '{16'd89,        16'hFF4C,     16'hFF42, 16'h7FFF,     16'h8000};
    vb = '{16'hFFF9,      16'h001D,     16'hFF42, 16'h7FFF,     16'h8000};
    ve = '{32'hFFFFFD91,  32'hFFFFEB9C, 32'd36100, 32'h3FFF0001, 32'h40000000};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_job(va[i], vb[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL signed_push%0d got accepted=0 want 1", i); end
    end
    for (int i = 0; i < 5; i++) begin
      wait_out_valid(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL signed_wait%0d got out_valid=0 want 1", i); end
      else if (out_result !== ve[i]) begin failures++; $display("FAIL signed_result%0d got %h want %h", i, out_result, ve[i]); end
      take_result();
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] ja [7];
    logic [W-1:0] jb [7];
    int acc;
    int t;
    bit ok;
    bit bad;
    logic [PW-1:0] e;
    for (int i = 0; i < 7; i++) begin ja[i] = rand_op(); jb[i] = rand_op(); end
    out_ready = 1'b0; acc = 0;
    for (int k = 0; k < 7; k++) begin
      in_a = ja[acc]; in_b = jb[acc]; in_valid = 1'b1;
      if (in_ready) begin exp_q.push_back(ref_prod(ja[acc], jb[acc])); acc++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (acc != 5) begin failures++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got in_ready=%b want 0", in_ready); end
    wait_out_valid(ok);
    bad = 1'b0;
    repeat (20) begin
      if (mul_start || in_ready) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin failures++; $display("FAIL bp_stall got issue_or_ready=1 want 0"); end
    for (int i = 0; i < 5; i++) begin
      t = 0; bad = 1'b0;
      while (!out_valid && t < 500) begin
        if (out_valid && mul_start) bad = 1'b1;
        @(negedge clk); t++;
      end
      if (out_valid && mul_start) bad = 1'b1;
      checks++; if (bad) begin failures++; $display("FAIL bp_overlap%0d got start_with_ov=1 want 0", i); end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      checks++;
      if (!out_valid) begin failures++; $display("FAIL bp_wait%0d got out_valid=0 want 1", i); end
      else if (out_result !== e) begin failures++; $display("FAIL bp_result%0d got %h want %h", i, out_result, e); end
      take_result();
    end
    repeat (20) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_drained got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL bp_no_err got %b want 0", err_timeout); end
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    int hi;
    logic [PW-1:0] eb;
    out_ready = 1'b0;
    never_irq = 1'b1;
    push_job(16'd11, 16'd13, ok);
    push_job(16'hFFFD, 16'd9, ok);
    eb = 32'hFFFFFFE5;
    t = 0;
    while (!mul_start && t < 50) begin @(negedge clk); t++; end
    checks++; if (!mul_start) begin failures++; $display("FAIL tmo_issue got start=0 want 1"); end
    hi = 0;
    while (mul_start && hi < 200) begin @(negedge clk); hi++; end
    never_irq = 1'b0;
    checks++; if (hi != int'(TMO)) begin failures++; $display("FAIL tmo_cycles got %0d want %0d", hi, TMO); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err got %b want 1", err_timeout); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tmo_no_result got ov=%b want 0", out_valid); end
    wait_out_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tmo_next_wait got out_valid=0 want 1"); end
    else if (out_result !== eb) begin failures++; $display("FAIL tmo_next_result got %h want %h", out_result, eb); end
    take_result();
    repeat (20) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL tmo_after got ov=%b err=%b want ov=0 err=1", out_valid, err_timeout); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    bit bad;
    int t;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_job(rand_op(), rand_op(), ok);
    t = 0;
    while (!mul_ack && t < 100) begin @(negedge clk); t++; end
    checks++; if (!mul_ack) begin failures++; $display("FAIL rmj_reach_ack got ack=0 want 1"); end
    resetn = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, mul_start, mul_ack, err_timeout, mul_irq_enable} !== 6'b000001) begin
      failures++; $display("FAIL rmj_async got rdy/ov/st/ack/err/ien=%b want 000001",
        {in_ready, out_valid, mul_start, mul_ack, err_timeout, mul_irq_enable}); end
    checks++; if (out_result !== '0 || mul_data_a !== '0 || mul_data_b !== '0) begin
      failures++; $display("FAIL rmj_data got res=%h a=%h b=%h want 0", out_result, mul_data_a, mul_data_b); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmj_ready got %b want 1", in_ready); end
    bad = 1'b0;
    repeat (30) begin
      if (out_valid || mul_start) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin failures++; $display("FAIL rmj_stale got activity=1 want 0"); end
    push_job(16'd5, 16'hFFFD, ok);
    wait_out_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmj_fresh_wait got out_valid=0 want 1"); end
    else if (out_result !== 32'hFFFFFFF1) begin failures++; $display("FAIL rmj_fresh got %h want fffffff1", out_result); end
    take_result();
  endtask

  task automatic test_random_stream();
    localparam int N = 40;
    int got;
    exp_q.delete();
    got = 0;
    fork
      begin : producer
        int sent;
        int cyc;
        bit acc_pending;
        sent = 0; cyc = 0; acc_pending = 1'b0;
        while (sent < N && cyc < 20000) begin
          if (acc_pending) begin in_valid = 1'b0; acc_pending = 1'b0; end
          if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(ref_prod(in_a, in_b)); sent++; acc_pending = 1'b1;
          end
          @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int cyc;
        logic [PW-1:0] e;
        cyc = 0;
        while (got < N && cyc < 20000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL rand_extra got %h want none", out_result);
            end else begin
              e = exp_q.pop_front();
              if (out_result !== e) begin failures++; $display("FAIL rand_result%0d got %h want %h", got, out_result, e); end
            end
            got++;
          end
          @(negedge clk); cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++; if (got != N) begin failures++; $display("FAIL rand_count got %0d want %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_basic_products();
    test_signed_extremes();
    test_back_pressure();
    test_timeout();
    test_reset_mid_job();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
